// File: rtl/muldiv_if.sv
// muldiv_if: request/response signals of the RV32M multiply/divide unit.
// The master drives the request (start/op/operands/kill); the slave is the unit.
interface muldiv_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, op, operand_a, operand_b, kill,
        input  busy, done, result
    );

    modport slave (
        input  start, op, operand_a, operand_b, kill,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Multiplication is radix-2 shift-add and division is radix-2 restoring,
// both on operand magnitudes with the sign fixed up in the DONE state.
// Optional macro MULDIV_FAST_MUL_EN replaces the iterative multiplier with a
// single-cycle 33x33 signed multiplier (IDLE -> DONE directly on accept).
module muldiv_unit (
    input  logic      clk,
    input  logic      rst_n,
    muldiv_if.slave   bus
);
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [5:0]            count;
    logic [2:0]            op_q;
    logic [DATA_W-1:0]     opnd;      // multiplicand (mul) or divisor (div) magnitude
    logic [DATA_W-1:0]     hi;        // product high half / partial remainder
    logic [DATA_W-1:0]     lo;        // multiplier / dividend-quotient shift register
    logic                  neg_a;
    logic                  neg_b;
    logic                  b_zero;
    logic                  busy;
    logic                  done_q;
    logic [DATA_W-1:0]     result_q;

    logic                  accept;
    logic                  step;
    logic                  finish;
    logic                  fast_sel;
    logic                  in_neg_a;
    logic                  in_neg_b;
    logic [DATA_W-1:0]     mag_a;
    logic [DATA_W-1:0]     mag_b;
    logic [DATA_W-1:0]     hi_nxt;
    logic [DATA_W-1:0]     lo_nxt;
    logic [DATA_W:0]       mul_sum;
    logic [DATA_W:0]       rem_shift;
    logic                  rem_ge;
    logic [2*DATA_W-1:0]   prod_signed;
    logic [DATA_W-1:0]     quo_signed;
    logic [DATA_W-1:0]     rem_signed;
    logic [DATA_W-1:0]     final_value;

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV, REM
    function automatic logic a_is_signed(input logic [2:0] f);
        return (f == 3'b000) || (f == 3'b001) || (f == 3'b010) ||
               (f == 3'b100) || (f == 3'b110);
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV, REM
    function automatic logic b_is_signed(input logic [2:0] f);
        return (f == 3'b000) || (f == 3'b001) || (f == 3'b100) || (f == 3'b110);
    endfunction

    function automatic logic [DATA_W-1:0] apply_sign32(input logic [DATA_W-1:0] x,
                                                       input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [2*DATA_W-1:0] apply_sign64(input logic [2*DATA_W-1:0] x,
                                                         input logic neg);
        return neg ? (~x + 64'd1) : x;
    endfunction

    assign in_neg_a = a_is_signed(bus.op) & bus.operand_a[DATA_W-1];
    assign in_neg_b = b_is_signed(bus.op) & bus.operand_b[DATA_W-1];
    assign mag_a    = apply_sign32(bus.operand_a, in_neg_a);
    assign mag_b    = apply_sign32(bus.operand_b, in_neg_b);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [DATA_W:0]     fast_a;
    logic signed [DATA_W:0]     fast_b;
    logic signed [2*DATA_W-1:0] fast_prod;

    assign fast_a    = {a_is_signed(bus.op) & bus.operand_a[DATA_W-1], bus.operand_a};
    assign fast_b    = {b_is_signed(bus.op) & bus.operand_b[DATA_W-1], bus.operand_b};
    assign fast_prod = 64'(fast_a) * 64'(fast_b);
    assign fast_sel  = ~bus.op[2];
`else
    assign fast_sel  = 1'b0;
`endif

    // State register: kill and reset both return to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: kill wins over everything, including a start seen in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = fast_sel ? DONE : CALC;
                end
            end
            CALC: begin
                if (bus.kill) begin
                    state_nxt = IDLE;
                end else if (count == 6'd31) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control outputs decoded from the current state
    always_comb begin
        busy   = (state != IDLE);
        accept = (state == IDLE) && bus.start && !bus.kill;
        step   = (state == CALC) && !bus.kill;
        finish = (state == DONE) && !bus.kill;
    end

    // One shift-add or restoring-divide iteration on the magnitude registers
    always_comb begin
        hi_nxt    = hi;
        lo_nxt    = lo;
        mul_sum   = '0;
        rem_shift = '0;
        rem_ge    = 1'b0;
        if (op_q[2]) begin
            rem_shift = {hi, lo[DATA_W-1]};
            rem_ge    = (rem_shift >= {1'b0, opnd});
            if (rem_ge) begin
                // Remainder after a successful subtract is below the divisor, so 32 bits suffice
                hi_nxt = rem_shift[DATA_W-1:0] - opnd;
                lo_nxt = {lo[DATA_W-2:0], 1'b1};
            end else begin
                hi_nxt = rem_shift[DATA_W-1:0];
                lo_nxt = {lo[DATA_W-2:0], 1'b0};
            end
        end else begin
            mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : 33'd0);
            hi_nxt  = mul_sum[DATA_W:1];
            lo_nxt  = {mul_sum[0], lo[DATA_W-1:1]};
        end
    end

    // Operand capture on accept, then one iteration per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            count  <= '0;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            b_zero <= 1'b0;
        end else if (accept) begin
            op_q   <= bus.op;
            count  <= '0;
            neg_a  <= in_neg_a;
            neg_b  <= in_neg_b;
            b_zero <= (bus.operand_b == '0);
            hi     <= '0;
            if (bus.op[2]) begin
                opnd <= mag_b;
                lo   <= mag_a;
            end else begin
                opnd <= mag_a;
                lo   <= mag_b;
            end
`ifdef MULDIV_FAST_MUL_EN
            // Signed product is final already, so the DONE-state sign fix is disabled
            if (!bus.op[2]) begin
                neg_a <= 1'b0;
                neg_b <= 1'b0;
                hi    <= fast_prod[2*DATA_W-1:DATA_W];
                lo    <= fast_prod[DATA_W-1:0];
            end
`endif
        end else if (step) begin
            count <= count + 6'd1;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
        end
    end

    // Sign fix-up and result selection performed while in DONE
    always_comb begin
        prod_signed = apply_sign64({hi, lo}, neg_a ^ neg_b);
        quo_signed  = apply_sign32(lo, neg_a ^ neg_b);
        rem_signed  = apply_sign32(hi, neg_a);
        // Divide by zero yields all ones; the remainder path already returns rs1
        if (b_zero) begin
            quo_signed = '1;
        end
        case (op_q)
            3'b000:                  final_value = prod_signed[DATA_W-1:0];
            3'b001, 3'b010, 3'b011:  final_value = prod_signed[2*DATA_W-1:DATA_W];
            3'b100, 3'b101:          final_value = quo_signed;
            default:                 final_value = rem_signed;
        endcase
    end

    // Result register and single-cycle done pulse on the DONE -> IDLE edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= finish;
            if (finish) begin
                result_q <= final_value;
            end
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit.
// Stimulus pushes expected result and latency; a negedge monitor pops on done.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];

    muldiv_if bus();

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done result=%h required=no done pulse", bus.result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (bus.result !== e.res) begin
                    failures++;
                    $display("FAIL %s_result actual=%h required=%h", e.name, bus.result, e.res);
                end
                checks++;
                if (cyc - e.acc != e.lat) begin
                    failures++;
                    $display("FAIL %s_latency actual=%0d required=%0d", e.name, cyc - e.acc, e.lat);
                end
            end
        end
    end

    // Called right after a negedge; start is accepted on the following posedge
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string nm, input bit push);
        bus.start     = 1'b1;
        bus.op        = f;
        bus.operand_a = a;
        bus.operand_b = b;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.op        = 3'($urandom);
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
        if (push) sb.push_back('{res: exp, acc: cyc, lat: (f[2] ? DIV_LAT : MUL_LAT), name: nm});
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no done in 100 cycles required=done", nm);
            sb.delete();
        end
    endtask

    task automatic expect_val(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.op        = 3'b000;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.kill      = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        expect_val("reset_busy",   32'(bus.busy), 32'd0);
        expect_val("reset_done",   32'(bus.done), 32'd0);
        expect_val("reset_result", bus.result,    32'h0);

        // Start on the first edge with reset released
        rst_n = 1'b1;
        issue(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul_neg", 1'b1);
        wait_idle("mul_neg");

        issue(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, "mulh", 1'b1);
        wait_idle("mulh");
        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu", 1'b1);
        wait_idle("mulhu");
        issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu", 1'b1);
        wait_idle("mulhsu");
        issue(3'b011, 32'h80000000, 32'd2, 32'h00000001, "mulhu_carry", 1'b1);
        wait_idle("mulhu_carry");
        issue(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_neg", 1'b1);
        wait_idle("div_neg");
        issue(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_neg", 1'b1);
        wait_idle("rem_neg");
        issue(3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, "divu", 1'b1);
        wait_idle("divu");
        issue(3'b101, 32'd100, 32'd7, 32'd14, "divu_small", 1'b1);
        wait_idle("divu_small");
        issue(3'b111, 32'd100, 32'd7, 32'd2, "remu_small", 1'b1);
        wait_idle("remu_small");
        issue(3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, "divu_zero", 1'b1);
        wait_idle("divu_zero");
        issue(3'b111, 32'd5, 32'd0, 32'd5, "remu_zero", 1'b1);
        wait_idle("remu_zero");
        issue(3'b100, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, "div_zero", 1'b1);
        wait_idle("div_zero");
        issue(3'b110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, "rem_zero", 1'b1);
        wait_idle("rem_zero");
        issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf", 1'b1);
        wait_idle("div_ovf");
        issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf", 1'b1);
        wait_idle("rem_ovf");

        // Start with new operands mid-calculation is ignored
        issue(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "start_ignored", 1'b1);
        repeat (9) @(negedge clk);
        expect_val("busy_in_calc", 32'(bus.busy), 32'd1);
        bus.start     = 1'b1;
        bus.op        = 3'b000;
        bus.operand_a = 32'd3;
        bus.operand_b = 32'd3;
        @(negedge clk);
        bus.start     = 1'b0;
        wait_idle("start_ignored");
        repeat (40) @(negedge clk);
        expect_val("idle_after_ignored", 32'(bus.busy), 32'd0);

        // Kill mid-calculation: back to idle, no done, result held
        issue(3'b000, 32'd7, 32'hFFFFFFFD, 32'h0, "killed", 1'b0);
        repeat (9) @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        expect_val("kill_busy",   32'(bus.busy), 32'd0);
        expect_val("kill_result", bus.result,    32'hFFFFFFFD);
        repeat (40) @(negedge clk);
        expect_val("kill_result_held", bus.result, 32'hFFFFFFFD);

        // Asynchronous reset mid-calculation clears outputs immediately
        issue(3'b101, 32'd1000, 32'd3, 32'h0, "reset_abort", 1'b0);
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        expect_val("rst_mid_busy",   32'(bus.busy), 32'd0);
        expect_val("rst_mid_done",   32'(bus.done), 32'd0);
        expect_val("rst_mid_result", bus.result,    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        expect_val("rst_release_busy", 32'(bus.busy), 32'd0);
        issue(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "after_reset", 1'b1);
        wait_idle("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port start  input  1  request new operation; sampled only in IDLE.
REQ-004 SHALL have port op  input  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port operand_a  input  32  rs1 value (multiplicand/dividend).
REQ-006 SHALL have port operand_b  input  32  rs2 value (multiplier/divisor).
REQ-007 SHALL have port kill  input  1  synchronous abort of in-flight operation (pipeline flush).
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port done  output  1  single-cycle pulse; result valid in that cycle.
REQ-010 SHALL have port result  output  32  operation result; holds until next accepted start.

Function
REQ-011 SHALL implement states IDLE, CALC, DONE; IDLE->CALC on start; CALC->DONE after 32 iterations; DONE->IDLE unconditionally next edge.
REQ-012 SHALL latch op, operand_a, operand_b on the edge start is accepted; later input changes have no effect on the operation.
REQ-013 SHALL ignore start in CALC and DONE (no queueing, no restart).
REQ-014 SHALL use a 6-bit iteration counter, cleared on accept, one iteration per CALC cycle, leaving CALC when count reaches 31.
REQ-015 SHALL give iterative latency: done high in the cycle following the 33rd rising edge after the accept edge (32 CALC cycles + DONE).
REQ-016 SHALL multiply by radix-2 shift-add on magnitudes, producing a 64-bit product; sign applied in DONE per op (MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned).
REQ-017 SHALL select product[31:0] for MUL, product[63:32] for MULH/MULHSU/MULHU.
REQ-018 SHALL divide by radix-2 restoring division on magnitudes; quotient sign = sign(a) XOR sign(b), remainder sign = sign(a) for DIV/REM.
REQ-019 SHALL, for divisor zero, return quotient 0xFFFFFFFF (DIV, DIVU) and remainder = operand_a (REM, REMU), with normal latency.
REQ-020 SHALL, for DIV/REM of 0x80000000 by 0xFFFFFFFF, return quotient 0x80000000 and remainder 0, with normal latency.
REQ-021 SHALL, on kill high in CALC or DONE, return to IDLE on the next edge with done low and result unchanged; kill in IDLE has no effect and has priority over start.
REQ-022 SHALL assert done for exactly one cycle per completed operation and never without a preceding accepted start.

Reset
REQ-023 SHALL, on rst_n low, immediately force state IDLE, counter 0, busy 0, done 0, result 0x00000000, all operand/accumulator registers 0.
REQ-024 SHALL abort any in-flight operation on reset, with no done pulse after reset release.
REQ-025 SHALL accept start on the first rising edge with rst_n high.

Configuration
REQ-026 SHALL recognise macro MULDIV_FAST_MUL_EN.
REQ-027 SHALL, with MULDIV_FAST_MUL_EN defined, compute MUL/MULH/MULHSU/MULHU with a single-cycle 33x33 signed multiplier: accept edge goes IDLE->DONE, done high the cycle after the accept edge.
REQ-028 SHALL, without MULDIV_FAST_MUL_EN, use the iterative multiplier of REQ-016 with REQ-015 latency; divide ops are iterative in both builds.

Verification
REQ-029 SHALL cover: MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 33 edges after accept (1 edge with MULDIV_FAST_MUL_EN).
REQ-030 SHALL cover: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 SHALL cover: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
REQ-032 SHALL cover: DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 % 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-033 SHALL cover: start pulsed with new operands at CALC iteration 10 -> ignored, original result delivered; kill at iteration 10 -> busy 0 next cycle, no done, result unchanged.
REQ-034 SHALL cover: rst_n low at CALC iteration 20 -> busy, done, result 0 immediately; no done within 40 cycles after release; next start completes normally.
